// File: rtl/fetch_unit.sv
// Instruction fetch: issues one memory read per fetch and holds the word until decode takes it.
// Latency: pc_addr sampled at edge N -> mem_req after N; mem_ack at N+1 -> instr_valid after N+1.
// Backpressure: instr_ready low holds instr/instr_addr in HOLD; hlt low-gates new fetches from IDLE.
module fetch_unit #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hlt,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_done,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Last counter value tolerated before the outstanding request is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              mem_req_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] instr_addr_d;
    logic              instr_valid_d;
    logic              fetch_done_d;
    logic              fetch_err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              drop_q, drop_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
            fetch_done  <= 1'b0;
            fetch_err   <= 1'b0;
            cnt_q       <= 8'd0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            instr       <= instr_d;
            instr_addr  <= instr_addr_d;
            instr_valid <= instr_valid_d;
            fetch_done  <= fetch_done_d;
            fetch_err   <= fetch_err_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req;
        mem_addr_d    = mem_addr;
        instr_d       = instr;
        instr_addr_d  = instr_addr;
        instr_valid_d = instr_valid;
        fetch_done_d  = 1'b0;
        fetch_err_d   = 1'b0;
        cnt_d         = cnt_q;
        drop_d        = drop_q;

        unique case (state_q)
            IDLE: begin
                // flush has nothing to discard here, so only hlt matters
                if (!hlt) begin
                    mem_addr_d = pc_addr;
                    mem_req_d  = 1'b1;
                    cnt_d      = 8'd0;
                    drop_d     = 1'b0;
                    state_d    = REQ;
                end else begin
                    mem_req_d = 1'b0;
                end
            end

            REQ: begin
                if (mem_ack) begin
                    // ack takes priority over a timeout landing on the same edge
                    instr_d      = mem_rdata;
                    instr_addr_d = mem_addr;
                    mem_req_d    = 1'b0;
                    drop_d       = 1'b0;
                    if (drop_q || flush) begin
                        instr_valid_d = 1'b0;
                        state_d       = IDLE;
                    end else begin
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    drop_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    // the read stays outstanding; a flush only marks its data for discard
                    cnt_d = cnt_q + 8'd1;
                    if (flush) begin
                        drop_d = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    fetch_done_d  = 1'b1;
                    state_d       = IDLE;
                end
            end

            default: begin
                mem_req_d     = 1'b0;
                instr_valid_d = 1'b0;
                drop_d        = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected {addr, word} per delivered instruction.
module tb_fetch_unit;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              hlt;
    logic              flush;
    logic [ADDR_W-1:0] pc_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic              fetch_done;
    logic              fetch_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W+DATA_W-1:0] sb[$];

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .hlt        (hlt),
        .flush      (flush),
        .pc_addr    (pc_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs driven 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag, input logic done, input logic err);
        chk({tag, "_done"}, 64'(fetch_done), 64'(done));
        chk({tag, "_err"}, 64'(fetch_err), 64'(err));
    endtask

    // Compare the delivered instruction against the oldest scoreboard entry.
    task automatic chk_instr(input string tag);
        logic [ADDR_W+DATA_W-1:0] e;
        chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
        chk({tag, "_sb_has_entry"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_instr"}, 64'(instr), 64'(e[DATA_W-1:0]));
            chk({tag, "_instr_addr"}, 64'(instr_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
        end
    endtask

    // Start a fetch from IDLE at the next edge, then block further fetches.
    task automatic start_fetch(input string tag, input logic [ADDR_W-1:0] a);
        hlt     = 1'b0;
        pc_addr = a;
        step();
        hlt = 1'b1;
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd1);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(a));
    endtask

    task automatic ack(input logic [DATA_W-1:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        hlt         = 1'b1;
        flush       = 1'b0;
        pc_addr     = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_addr", 64'(instr_addr), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk_pulses("rst", 1'b0, 1'b0);
        reset = 1'b1;

        // hlt held in IDLE for 5 cycles, then released
        pc_addr = 10'h005;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hlt_mem_req", 64'(mem_req), 64'd0);
        end

        // Basic fetch with minimum latency and immediate acceptance
        start_fetch("basic", 10'h005);
        instr_ready = 1'b1;
        sb.push_back({10'h005, 32'hDEADBEEF});
        ack(32'hDEADBEEF);
        chk_instr("basic");
        chk("basic_req_low", 64'(mem_req), 64'd0);
        chk_pulses("basic_hold", 1'b0, 1'b0);
        step();
        chk("basic_valid_drop", 64'(instr_valid), 64'd0);
        chk_pulses("basic_accept", 1'b1, 1'b0);
        step();
        chk_pulses("basic_after", 1'b0, 1'b0);

        // Backpressure: instr held while pc_addr moves
        instr_ready = 1'b0;
        start_fetch("bp", 10'h0A3);
        sb.push_back({10'h0A3, 32'hCAFEF00D});
        ack(32'hCAFEF00D);
        chk_instr("bp");
        for (int i = 0; i < 3; i++) begin
            pc_addr = 10'(10'h100 + i * 7);
            step();
            chk("bp_stable_instr", 64'(instr), 64'hCAFEF00D);
            chk("bp_stable_addr", 64'(instr_addr), 64'h0A3);
            chk("bp_stable_valid", 64'(instr_valid), 64'd1);
            chk_pulses("bp_wait", 1'b0, 1'b0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("bp_valid_drop", 64'(instr_valid), 64'd0);
        chk_pulses("bp_accept", 1'b1, 1'b0);
        step();
        chk_pulses("bp_after", 1'b0, 1'b0);

        // Timeout: request stays up TIMEOUT cycles, then an error pulse
        start_fetch("to", 10'h3FF);
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            chk("to_req_held", 64'(mem_req), 64'd1);
            chk("to_addr_held", 64'(mem_addr), 64'h3FF);
            chk_pulses("to_wait", 1'b0, 1'b0);
        end
        step();
        chk("to_req_low", 64'(mem_req), 64'd0);
        chk_pulses("to_fire", 1'b0, 1'b1);
        step();
        chk("to_idle_req", 64'(mem_req), 64'd0);
        chk_pulses("to_after", 1'b0, 1'b0);

        // Ack on the timeout edge: ack wins
        start_fetch("race", 10'h111);
        for (int i = 1; i < TIMEOUT; i++) step();
        chk("race_req_held", 64'(mem_req), 64'd1);
        sb.push_back({10'h111, 32'hA5A55A5A});
        ack(32'hA5A55A5A);
        chk_instr("race");
        chk_pulses("race", 1'b0, 1'b0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_pulses("race_accept", 1'b1, 1'b0);

        // Flush during REQ, ack three cycles later: data discarded
        start_fetch("fl_req", 10'h010);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_req_not_withdrawn", 64'(mem_req), 64'd1);
        step();
        step();
        ack(32'h12345678);
        chk("fl_req_valid", 64'(instr_valid), 64'd0);
        chk("fl_req_req_low", 64'(mem_req), 64'd0);
        chk_pulses("fl_req", 1'b0, 1'b0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("fl_req_valid2", 64'(instr_valid), 64'd0);
        chk_pulses("fl_req2", 1'b0, 1'b0);

        // Flush on the same edge as ack
        start_fetch("fl_ack", 10'h020);
        flush = 1'b1;
        ack(32'h0BADF00D);
        flush = 1'b0;
        chk("fl_ack_valid", 64'(instr_valid), 64'd0);
        chk_pulses("fl_ack", 1'b0, 1'b0);

        // Flush in HOLD overrides instr_ready
        start_fetch("fl_hold", 10'h030);
        sb.push_back({10'h030, 32'h13579BDF});
        ack(32'h13579BDF);
        chk_instr("fl_hold");
        flush       = 1'b1;
        instr_ready = 1'b1;
        step();
        flush       = 1'b0;
        instr_ready = 1'b0;
        chk("fl_hold_valid", 64'(instr_valid), 64'd0);
        chk_pulses("fl_hold", 1'b0, 1'b0);

        // Stray ack while IDLE changes nothing
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_valid", 64'(instr_valid), 64'd0);
        chk("idle_ack_req", 64'(mem_req), 64'd0);
        chk("idle_ack_instr", 64'(instr), 64'h13579BDF);

        // Flush in IDLE does not block a fetch starting on the same edge
        flush = 1'b1;
        start_fetch("fl_idle", 10'h040);
        flush = 1'b0;
        sb.push_back({10'h040, 32'h2468ACE0});
        ack(32'h2468ACE0);
        chk_instr("fl_idle");
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_pulses("fl_idle_accept", 1'b1, 1'b0);

        // Asynchronous reset mid-REQ
        start_fetch("arst", 10'h2AA);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_req", 64'(mem_req), 64'd0);
        chk("arst_mem_addr", 64'(mem_addr), 64'd0);
        chk("arst_instr", 64'(instr), 64'd0);
        chk("arst_instr_addr", 64'(instr_addr), 64'd0);
        chk("arst_valid", 64'(instr_valid), 64'd0);
        chk_pulses("arst", 1'b0, 1'b0);
        step();
        chk_pulses("arst_held", 1'b0, 1'b0);

        // First fetch begins on the first edge after release with hlt low
        hlt     = 1'b0;
        pc_addr = 10'h055;
        reset   = 1'b1;
        step();
        hlt = 1'b1;
        chk("first_mem_req", 64'(mem_req), 64'd1);
        chk("first_mem_addr", 64'(mem_addr), 64'h055);
        sb.push_back({10'h055, 32'h0F0F0F0F});
        ack(32'h0F0F0F0F);
        chk_instr("first");
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk_pulses("first_accept", 1'b1, 1'b0);

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
